// File: rtl/out_signature_checker_if.sv
// Response-side bus of the stimulus/response harness.
//   master : drives the run controls (start, num_samples, expected_sig) and
//            the monitored DUT output stream (out_flat, out_valid);
//            observes status (busy, done, pass, sig, sample_cnt).
//   slave  : the signature checker itself.
interface out_signature_checker_if #(
  parameter int OUT_W = 159
);
  logic             start;
  logic [31:0]      num_samples;
  logic [OUT_W-1:0] out_flat;
  logic             out_valid;
  logic [31:0]      expected_sig;
  logic             busy;
  logic             done;
  logic             pass;
  logic [31:0]      sig;
  logic [31:0]      sample_cnt;

  modport master (
    output start, num_samples, out_flat, out_valid, expected_sig,
    input  busy, done, pass, sig, sample_cnt
  );

  modport slave (
    input  start, num_samples, out_flat, out_valid, expected_sig,
    output busy, done, pass, sig, sample_cnt
  );
endinterface

// File: rtl/out_signature_checker.sv
// out_signature_checker
//   Folds each valid out_flat sample into a 32-bit MISR over a programmed
//   number of samples, then compares against expected_sig.
// Ports:
//   clk        : clock, all state on rising edge
//   rst        : synchronous active-high reset
//   bus.start        : one-cycle run start, honoured in IDLE/DONE only
//   bus.num_samples  : valid samples to fold, captured on start
//   bus.out_flat     : monitored DUT output vector (OUT_W bits)
//   bus.out_valid    : out_flat carries a sample this cycle
//   bus.expected_sig : golden signature, sampled on the completing edge
//   bus.busy / done  : run in progress / run complete (held)
//   bus.pass         : sig matched expected_sig (meaningful while done)
//   bus.sig          : current signature
//   bus.sample_cnt   : samples folded in the current run
module out_signature_checker #(
  parameter int          OUT_W = 159,
  parameter logic [31:0] SEED  = 32'hFFFFFFFF,
  parameter logic [31:0] POLY  = 32'h04C11DB7
) (
  input  logic                  clk,
  input  logic                  rst,
  out_signature_checker_if.slave bus
);

  localparam int NCHUNK = (OUT_W + 31) / 32;
  localparam int PAD_W  = NCHUNK * 32;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] sig_q, sig_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic        pass_q, pass_d;

  // Zero-pad to a whole number of 32-bit chunks, then XOR-compress.
  logic [PAD_W-1:0]             padded;
  logic [NCHUNK-1:0][31:0]      chunk;
  logic [NCHUNK:0][31:0]        fold_acc;
  logic [31:0]                  fold;
  logic [31:0]                  misr_next;

  always_comb begin
    padded              = '0;
    padded[OUT_W-1:0]   = bus.out_flat;
  end

  assign fold_acc[0] = '0;
  for (genvar c = 0; c < NCHUNK; c++) begin : g_fold
    assign chunk[c]      = padded[c*32 +: 32];
    assign fold_acc[c+1] = fold_acc[c] ^ chunk[c];
  end
  assign fold = fold_acc[NCHUNK];

  assign misr_next = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? POLY : 32'h0) ^ fold;

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          sig_d  = SEED;
          cnt_d  = '0;
          rem_d  = bus.num_samples;
          pass_d = 1'b0;
          if (bus.num_samples == 32'd0) begin
            // Empty run completes immediately on the unfolded seed.
            state_d = DONE;
            pass_d  = (SEED == bus.expected_sig);
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (bus.out_valid) begin
          sig_d = misr_next;
          cnt_d = cnt_q + 32'd1;
          rem_d = rem_q - 32'd1;
          // Completion shares the edge of the final fold.
          if (rem_q == 32'd1) begin
            state_d = DONE;
            pass_d  = (misr_next == bus.expected_sig);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      rem_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.busy       = (state_q == RUN);
  assign bus.done       = (state_q == DONE);
  assign bus.pass       = pass_q;
  assign bus.sig        = sig_q;
  assign bus.sample_cnt = cnt_q;

endmodule

// File: tb/tb_out_signature_checker.sv
module tb_out_signature_checker;
  localparam logic [31:0] SEED = 32'hFFFFFFFF;
  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  out_signature_checker_if #(.OUT_W(159)) bus ();

  out_signature_checker #(.OUT_W(159), .SEED(SEED), .POLY(POLY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: run-level view of the checker.
  logic [31:0] m_sig, m_cnt, m_rem;
  bit          m_run, m_done, m_pass;

  function automatic logic [31:0] fold_f(input logic [158:0] v);
    logic [159:0] p;
    logic [31:0]  r;
    p = {1'b0, v};
    r = '0;
    for (int i = 0; i < 5; i++) r ^= p[i*32 +: 32];
    return r;
  endfunction

  function automatic logic [31:0] misr_f(input logic [31:0] s, input logic [31:0] f);
    return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, advance the model by the same edge, check all outputs.
  task automatic step(input bit r, input bit st, input logic [31:0] n, input logic [31:0] e,
                      input logic [158:0] v, input bit vld, input string tag);
    rst = r; bus.start = st; bus.num_samples = n; bus.expected_sig = e;
    bus.out_flat = v; bus.out_valid = vld;
    @(posedge clk);
    #1;
    if (r) begin
      m_run = 0; m_done = 0; m_sig = SEED; m_cnt = 0; m_pass = 0; m_rem = 0;
    end else if (st && !m_run) begin
      m_sig = SEED; m_cnt = 0; m_pass = 0; m_rem = n;
      if (n == 0) begin m_done = 1; m_pass = (SEED == e); end
      else begin m_run = 1; m_done = 0; end
    end else if (m_run && vld) begin
      m_sig = misr_f(m_sig, fold_f(v));
      m_cnt++;
      m_rem--;
      if (m_rem == 0) begin m_run = 0; m_done = 1; m_pass = (m_sig == e); end
    end
    chk({tag, ".sig"},  bus.sig,        m_sig);
    chk({tag, ".cnt"},  bus.sample_cnt, m_cnt);
    chk({tag, ".busy"}, 32'(bus.busy),  32'(m_run));
    chk({tag, ".done"}, 32'(bus.done),  32'(m_done));
    chk({tag, ".pass"}, 32'(bus.pass),  32'(m_pass));
  endtask

  initial begin
    logic [158:0] zero, v;
    logic [159:0] rnd;
    logic [158:0] smp[$];
    logic [31:0]  golden, e;
    int           n, idx, guard;
    bit           vld;
    zero = '0;
    bus.start = 0; bus.num_samples = 0; bus.expected_sig = 0;
    bus.out_flat = '0; bus.out_valid = 0;

    // Reset
    step(1, 0, 0, 0, zero, 0, "rst0");
    step(1, 0, 0, 0, zero, 0, "rst1");
    chk("rst.sig_const", bus.sig, 32'hFFFFFFFF);
    chk("rst.cnt_const", bus.sample_cnt, 32'h0);

    // Single zero sample -> known signature, pass
    step(0, 1, 1, 32'hFB3EE249, zero, 0, "one_start");
    step(0, 0, 0, 32'hFB3EE249, zero, 1, "one_fold");
    chk("one.sig_const", bus.sig, 32'hFB3EE249);
    chk("one.pass_const", 32'(bus.pass), 32'd1);

    // Bit 0 set -> signature differs, fail
    v = zero; v[0] = 1'b1;
    step(0, 1, 1, 32'hFB3EE249, zero, 0, "b0_start");
    step(0, 0, 0, 32'hFB3EE249, v, 1, "b0_fold");
    chk("b0.sig_const", bus.sig, 32'hFB3EE248);
    chk("b0.pass_const", 32'(bus.pass), 32'd0);

    // Expected value changes after completion do not disturb pass
    step(0, 0, 0, 32'hFB3EE248, zero, 0, "b0_hold");

    // Chunk aliasing: bits 0 and 32 cancel
    v = zero; v[0] = 1'b1; v[32] = 1'b1;
    step(0, 1, 1, 32'hFB3EE249, zero, 0, "alias_start");
    step(0, 0, 0, 32'hFB3EE249, v, 1, "alias_fold");
    chk("alias.sig_const", bus.sig, 32'hFB3EE249);

    // Top bit of the vector lands in chunk 4
    v = zero; v[158] = 1'b1;
    step(0, 1, 1, 32'h0, zero, 0, "top_start");
    step(0, 0, 0, 32'h0, v, 1, "top_fold");
    chk("top.sig_const", bus.sig, 32'hFB3EE249 ^ 32'h40000000);

    // Gaps: n=3, valid 1,0,0,1,1
    step(0, 1, 3, 32'h0, zero, 0, "gap_start");
    step(0, 0, 0, 32'h0, 159'h11, 1, "gap1");
    step(0, 0, 0, 32'h0, 159'h22, 0, "gap2");
    step(0, 0, 0, 32'h0, 159'h33, 0, "gap3");
    step(0, 0, 0, 32'h0, 159'h44, 1, "gap4");
    chk("gap4.done_const", 32'(bus.done), 32'd0);
    step(0, 0, 0, 32'h0, 159'h55, 1, "gap5");
    chk("gap5.done_const", 32'(bus.done), 32'd1);
    chk("gap5.cnt_const", bus.sample_cnt, 32'd3);

    // Zero-length runs
    step(0, 1, 0, 32'hFFFFFFFF, zero, 1, "zl_pass");
    chk("zl.pass_const", 32'(bus.pass), 32'd1);
    step(0, 1, 0, 32'h12345678, zero, 1, "zl_fail");
    chk("zl.sig_const", bus.sig, 32'hFFFFFFFF);

    // Reset mid-run, then a normal run
    step(0, 1, 5, 32'h0, zero, 0, "mr_start");
    step(0, 0, 0, 32'h0, 159'h7, 1, "mr1");
    step(0, 0, 0, 32'h0, 159'h9, 1, "mr2");
    step(1, 0, 0, 32'h0, zero, 0, "mr_rst");
    chk("mr.cnt_const", bus.sample_cnt, 32'd0);
    step(0, 1, 2, 32'h0, zero, 0, "mr_restart");
    step(0, 0, 0, 32'h0, 159'h3, 1, "mr_a");
    step(0, 0, 0, 32'h0, 159'h4, 1, "mr_b");

    // start in RUN is ignored
    step(0, 1, 3, 32'h0, zero, 0, "ig_start");
    step(0, 0, 0, 32'h0, 159'hA, 1, "ig1");
    step(0, 1, 7, 32'h0, 159'hB, 1, "ig_pulse");
    step(0, 0, 0, 32'h0, 159'hC, 1, "ig3");
    chk("ig.done_const", 32'(bus.done), 32'd1);

    // start in DONE reseeds; rst beats simultaneous start
    step(0, 1, 2, 32'h0, zero, 1, "dn_restart");
    chk("dn.sig_const", bus.sig, SEED);
    step(0, 0, 0, 32'h0, 159'h1, 1, "dn1");
    step(1, 1, 4, 32'h0, zero, 0, "rst_vs_start");
    step(0, 0, 0, 32'h0, zero, 1, "idle_valid");

    // Randomised runs against a golden computed from the whole sample list
    for (int r = 0; r < 16; r++) begin
      n = $urandom_range(1, 8);
      smp.delete();
      golden = SEED;
      for (int i = 0; i < n; i++) begin
        rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
        smp.push_back(rnd[158:0]);
        golden = misr_f(golden, fold_f(rnd[158:0]));
      end
      e = ($urandom_range(0, 1) == 1) ? golden : golden ^ (32'h1 << $urandom_range(0, 31));
      rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
      step(0, 1, n, e, rnd[158:0], 1, "rnd_start");
      idx = 0; guard = 0;
      while (idx < n && guard < 200) begin
        vld = ($urandom_range(0, 2) != 0);
        rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
        step(0, vld ? 1'b0 : 1'($urandom_range(0, 1)), 32'($urandom), e,
             vld ? smp[idx] : rnd[158:0], vld, "rnd");
        if (vld) idx++;
        guard++;
      end
      chk("rnd.final_sig", bus.sig, golden);
      chk("rnd.final_pass", 32'(bus.pass), 32'(e == golden));
      chk("rnd.final_cnt", bus.sample_cnt, 32'(n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/out_signature_checker.md
Name: out_signature_checker

Overview:
- Response-side end of the stimulus/response harness: the stimulus side drives the DUT's in_flat; this block consumes the DUT's out_flat stream.
- Folds each valid out_flat sample into a 32-bit MISR signature over a programmed number of samples.
- When the run completes, it compares the signature against an expected value and reports pass/fail.
- Sits beside the top-level DUT in self-checking regressions, so per-cycle text-log comparison is not needed.

Parameters:
OUT_W, 159, width of the monitored DUT output vector
SEED, 32'hFFFFFFFF, signature value at reset and at run start
POLY, 32'h04C11DB7, MISR feedback polynomial

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse that begins a run; sampled only in IDLE or DONE
num_samples  input  32  number of valid samples to fold; captured on start
out_flat  input  OUT_W  DUT output vector
out_valid  input  1  out_flat holds a sample to fold this cycle
expected_sig  input  32  golden signature; compared when the run completes
busy  output  1  high in RUN
done  output  1  high in DONE, held until the next start or rst
pass  output  1  valid while done=1; 1 when sig==expected_sig
sig  output  32  current signature register
sample_cnt  output  32  valid samples folded in the current run

Behaviour:
- Reset (rst=1 at a clock edge) takes effect on that edge: state=IDLE, sig=SEED, sample_cnt=0, busy=0, done=0, pass=0. This applies from any state, including mid-run.
- Fold step: zero-pad out_flat to 160 bits, then XOR the five 32-bit chunks together to form fold[31:0].
- MISR update: sig_next = {sig[30:0],1'b0} ^ (sig[31] ? POLY : 0) ^ fold.
- IDLE, start=1 at edge k:
  - latch remaining=num_samples, sig=SEED, sample_cnt=0, pass=0;
  - if num_samples==0, go directly to DONE (done=1 after edge k, pass evaluated on SEED);
  - otherwise go to RUN (busy=1 after edge k).
- RUN: at each edge with out_valid=1, apply the MISR update, increment sample_cnt, and decrement remaining.
  - out_valid=0: hold sig, sample_cnt and remaining.
  - When the final sample folds (remaining==1 and out_valid=1) at edge m: go to DONE, set pass = (sig_next == expected_sig). done=1 and busy=0 are visible after edge m.
  - start is ignored in RUN.
- DONE: sig, sample_cnt and pass hold. start=1 restarts exactly as from IDLE, same cycle rules.
- expected_sig is sampled only on the completing edge; later changes do not alter pass.
- sample_cnt wraps modulo 2^32; no saturation is required.
- Simultaneous rst and start: rst wins.
- Latency summary:
  - the start edge produces no fold;
  - the first fold can occur on the edge after start;
  - done rises on the same edge as the final fold, so there is no extra cycle.

Test Plan:
- Reset sequence: hold rst=1 for 2 cycles -> sig=0xFFFFFFFF, done=0, busy=0, pass=0, sample_cnt=0.
- start with num_samples=1, out_flat=0, out_valid=1, expected_sig=0xFB3EE249 -> after one fold: sig=0xFB3EE249, done=1, pass=1, sample_cnt=1.
- Same stimulus but out_flat=1 and expected_sig=0xFB3EE249 -> sig=0xFB3EE248, pass=0, done=1.
- Chunk aliasing: out_flat bits 0 and 32 set, num_samples=1 -> fold=0, sig=0xFB3EE249.
- Gaps and zero length:
  - num_samples=3 with out_valid pattern 1,0,0,1,1 -> done rises on the edge of the 5th pattern cycle, sample_cnt=3;
  - num_samples=0 -> done=1 one edge after start, sig=0xFFFFFFFF, pass=(expected_sig==0xFFFFFFFF).
- Reset and restart: rst during RUN after 2 of 5 samples -> IDLE, sig=0xFFFFFFFF, sample_cnt=0; a following start behaves normally. start pulsed in RUN -> no effect. start in DONE -> new run begins with sig reseeded.
